dac_frame_tx: RTL

Serializes one DAC command word per request onto a mode-0 SPI link (sclk idle low, MSB first, data changes on falling edge) toward the external DAC. Sits directly downstream of the modulation/mixing stage: the mixer's 16-bit output word plus its sample strobe arrive here. A one-entry holding buffer lets a new sample arrive while the previous frame is still shifting. A sticky overrun flag records samples dropped because the buffer was full.

---
 rtl/dac_tx_pkg.sv | 7 +
 rtl/dac_sclk_tick.sv | 17 +
 rtl/dac_frame_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg: shared state encoding and width helper for the DAC SPI frame transmitter
package dac_tx_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dac_sclk_tick.sv
// dac_sclk_tick: one-cycle tick every SCLK_HALF cycles while enabled, counter cleared when idle
module dac_sclk_tick
  import dac_tx_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int HW = clog2_min1(SCLK_HALF + 1);
  logic [HW-1:0] cnt;
  assign tick = en && cnt == HW'(SCLK_HALF - 1);
  always_ff @(posedge sys_clk)
    cnt <= (rst || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/dac_frame_tx.sv
// dac_frame_tx: buffers one sample word and serializes it MSB first onto a mode-0 SPI link
module dac_frame_tx
  import dac_tx_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int SCLK_HALF  = 1,
  parameter int CSB_GAP    = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb
);
  localparam int BW = clog2_min1(WORD_WIDTH);
  localparam int GW = clog2_min1(CSB_GAP + 1);
  state_t state, state_n;
  logic [WORD_WIDTH-1:0] sr, sr_n, hold;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic ph, ph_n, full, load, accept, active, tick;
  assign in_ready = !full && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = state != IDLE || full;
  assign active   = state == LEAD || state == SHIFT || state == TRAIL;
  dac_sclk_tick #(.SCLK_HALF(SCLK_HALF)) u_tick (
    .sys_clk(sys_clk),
    .rst(rst),
    .en(active),
    .tick(tick)
  );
  // ph is the internal sclk level; the shift register advances on its falling transition
  always_comb begin
    state_n = state;
    sr_n = sr;
    bit_n = bit_cnt;
    ph_n = ph;
    gap_n = '0;
    load = 1'b0;
    unique case (state)
      IDLE: if (full) begin
        load = 1'b1;
        sr_n = hold;
        bit_n = BW'(WORD_WIDTH - 1);
        state_n = LEAD;
      end
      LEAD: if (tick) begin
        ph_n = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: if (tick) begin
        if (ph) begin
          ph_n = 1'b0;
          if (bit_cnt != '0) sr_n = sr << 1;
        end else if (bit_cnt == '0) state_n = TRAIL;
        else begin
          ph_n = 1'b1;
          bit_n = bit_cnt - 1'b1;
        end
      end
      TRAIL: if (tick) state_n = GAP;
      GAP: begin
        gap_n = gap_cnt + 1'b1;
        if (gap_cnt == GW'(CSB_GAP - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the current state, so every phase is seen one cycle later on the pins
  always_ff @(posedge sys_clk) begin
    sr <= sr_n;
    bit_cnt <= bit_n;
    gap_cnt <= gap_n;
    if (accept) hold <= in_data;
    if (rst) begin
      state <= IDLE;
      ph <= 1'b0;
      full <= 1'b0;
      overrun <= 1'b0;
      csb <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      full <= accept || (full && !load);
      overrun <= overrun || (in_valid && !in_ready);
      csb <= !active;
      sclk <= ph && state == SHIFT;
      mosi <= active && sr[WORD_WIDTH-1];
    end
  end
endmodule
